// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider bank and other slow-clock timing blocks.
package clk_div_pkg;

    // Default divisor width used by timing blocks that do not override it.
    localparam int DIV_W_DEF = 8;

    // Channel-select width: clog2 of the channel count, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow divisor, phase counter, registered
// enable pulse and square-wave outputs. Divisor changes land only at period
// boundaries, on sync, or one edge later when the channel is disabled.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             sync,
    output logic             en,
    output logic             clk_out,
    output logic             pending
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W:0]   ONE_X     = (DIV_W + 1)'(1);

    logic [DIV_W-1:0] ph;
    logic [DIV_W-1:0] d_act;
    logic [DIV_W-1:0] d_sh;

    logic             wrap;
    logic             high;
    logic             apply;
    logic [DIV_W-1:0] new_div;
    logic [DIV_W:0]   half_up;

    // Decode the period boundary, the high/low half and the divisor to apply.
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        wrap    = 1'b0;
        high    = 1'b0;
        half_up = '0;
        if (d_act != '0) begin
            wrap    = (ph == d_act - 1'b1);
            half_up = ({1'b0, d_act} + ONE_X) >> 1;
            high    = ({1'b0, ph} < half_up);
        end
        // A write on the applying edge goes straight through to the active divisor.
        apply   = wr | pending;
        new_div = wr ? wr_div : d_sh;
    end

    // Channel state: reset, then sync, then disabled-channel apply, then count/wrap.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: every register here is a plain flop (no memory array), so all of them are reset.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            ph      <= '0;
            d_act   <= RESET_DIV;
            d_sh    <= RESET_DIV;
            pending <= 1'b0;
            en      <= 1'b0;
            clk_out <= 1'b0;
        end else if (sync) begin
            ph      <= '0;
            en      <= 1'b0;
            clk_out <= 1'b0;
            if (apply) begin
                d_act   <= new_div;
                d_sh    <= new_div;
                pending <= 1'b0;
            end
        end else if (d_act == '0) begin
            // Disabled: outputs held low; a pending divisor is picked up one edge
            // after it was written, and a fresh write restarts that wait.
            ph      <= '0;
            en      <= 1'b0;
            clk_out <= 1'b0;
            if (wr) begin
                d_sh    <= wr_div;
                pending <= 1'b1;
            end else if (pending) begin
                d_act   <= d_sh;
                pending <= 1'b0;
            end
        end else begin
            en      <= wrap;
            clk_out <= high;
            if (wrap) begin
                ph <= '0;
                if (apply) begin
                    d_act   <= new_div;
                    d_sh    <= new_div;
                    pending <= 1'b0;
                end
            end else begin
                ph <= ph + 1'b1;
                if (wr) begin
                    d_sh    <= wr_div;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent integer clock dividers sharing one clock.
// The top level only decodes the configuration channel select; writes to a
// channel index at or beyond NCH match no channel and are dropped.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int  NCH         = 4,
    parameter int  DIV_W       = DIV_W_DEF,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = ch_w(NCH)
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             sync_i,
    output logic [NCH-1:0]   en_o,
    output logic [NCH-1:0]   clk_o,
    output logic [NCH-1:0]   pending_o
);

    logic [NCH-1:0] wr;

    // One-hot write strobe per channel; out-of-range selects leave it all zero.
    always_comb begin
        wr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && (cfg_ch == CH_W'(c))) begin
                wr[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i   (clk_i),
            .rst     (rst),
            .wr      (wr[c]),
            .wr_div  (cfg_div),
            .sync    (sync_i),
            .en      (en_o[c]),
            .clk_out (clk_o[c]),
            .pending (pending_o[c])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus a random run,
// all compared against a per-channel behavioural model.
module tb_clk_div_bank;

    localparam int NCH   = 5;
    localparam int DIV_W = 8;
    localparam int DEF   = 4;
    localparam int CH_W  = 3;

    logic             clk_i   = 1'b0;
    logic             rst     = 1'b0;
    logic             cfg_we  = 1'b0;
    logic [CH_W-1:0]  cfg_ch  = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             sync_i  = 1'b0;
    logic [NCH-1:0]   en_o;
    logic [NCH-1:0]   clk_o;
    logic [NCH-1:0]   pending_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state per channel.
    int             m_act [NCH];
    int             m_sh  [NCH];
    int             m_ph  [NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_en;
    logic [NCH-1:0] m_clk;

    clk_div_bank #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sync_i    (sync_i),
        .en_o      (en_o),
        .clk_o     (clk_o),
        .pending_o (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Apply one clock edge of the divider rules to every channel.
    task automatic model_step(input bit r, input bit we, input int ch, input int dv, input bit sy);
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            wr = we && (ch == c);
            if (!r) begin
                m_act[c] = DEF; m_sh[c] = DEF; m_ph[c] = 0;
                m_pend[c] = 0; m_en[c] = 0; m_clk[c] = 0;
            end else if (sy) begin
                m_en[c] = 0; m_clk[c] = 0; m_ph[c] = 0;
                if (wr) begin
                    m_act[c] = dv; m_sh[c] = dv; m_pend[c] = 0;
                end else if (m_pend[c]) begin
                    m_act[c] = m_sh[c]; m_pend[c] = 0;
                end
            end else if (m_act[c] == 0) begin
                m_en[c] = 0; m_clk[c] = 0; m_ph[c] = 0;
                if (wr) begin
                    m_sh[c] = dv; m_pend[c] = 1;
                end else if (m_pend[c]) begin
                    m_act[c] = m_sh[c]; m_pend[c] = 0;
                end
            end else begin
                m_en[c]  = (m_ph[c] == m_act[c] - 1);
                m_clk[c] = (m_ph[c] < (m_act[c] + 1) / 2);
                if (m_en[c]) begin
                    m_ph[c] = 0;
                    if (wr) begin
                        m_act[c] = dv; m_sh[c] = dv; m_pend[c] = 0;
                    end else if (m_pend[c]) begin
                        m_act[c] = m_sh[c]; m_pend[c] = 0;
                    end
                end else begin
                    m_ph[c] = m_ph[c] + 1;
                    if (wr) begin
                        m_sh[c] = dv; m_pend[c] = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare after it.
    task automatic cycle(input bit r, input bit we, input int ch, input int dv, input bit sy);
        rst     = r;
        cfg_we  = we;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(dv);
        sync_i  = sy;
        @(posedge clk_i);
        model_step(r, we, ch, dv, sy);
        #1;
        check_vec("en_o", en_o, m_en);
        check_vec("clk_o", clk_o, m_clk);
        check_vec("pending_o", pending_o, m_pend);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
    endtask

    // After reset with DEFAULT_DIV=4: clk 1,1,0,0 from edge 1, en on edges 4,8,12.
    task automatic check_default_pattern(input string tag);
        for (int k = 1; k <= 12; k++) begin
            cycle(1, 0, 0, 0, 0);
            check_bit({tag, "_clk0"}, clk_o[0], ((k - 1) % 4) < 2);
            check_bit({tag, "_en0"}, en_o[0], (k % 4) == 0);
        end
    endtask

    initial begin
        // Reset state.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_vec("reset_en", en_o, '0);
        check_vec("reset_clk", clk_o, '0);
        check_vec("reset_pending", pending_o, '0);
        check_default_pattern("rst_seq");

        // Write ch1 div=3 while its phase is 1 of a 4-cycle period.
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 3, 0);
        check_bit("ch1_pending_set", pending_o[1], 1'b1);
        cycle(1, 0, 0, 0, 0);
        check_bit("ch1_pending_hold", pending_o[1], 1'b1);
        cycle(1, 0, 0, 0, 0);
        check_bit("ch1_old_wrap_en", en_o[1], 1'b1);
        check_bit("ch1_pending_clr", pending_o[1], 1'b0);
        idle(12);

        // Disable ch2, then re-enable it with divisor 5.
        cycle(1, 1, 2, 0, 0);
        idle(6);
        check_bit("ch2_disabled_clk", clk_o[2], 1'b0);
        cycle(1, 1, 2, 5, 0);
        idle(14);

        // Load 2,3,4,7,5 and pulse sync: everything low, then all rise together.
        cycle(1, 1, 0, 2, 0);
        cycle(1, 1, 1, 3, 0);
        cycle(1, 1, 2, 4, 0);
        cycle(1, 1, 3, 7, 0);
        cycle(1, 1, 4, 5, 0);
        idle(9);
        cycle(1, 0, 0, 0, 1);
        check_vec("sync_en", en_o, '0);
        check_vec("sync_clk", clk_o, '0);
        check_vec("sync_pending", pending_o, '0);
        cycle(1, 0, 0, 0, 0);
        check_vec("align_clk", clk_o, '1);
        idle(16);

        // Out-of-range channel selects are ignored.
        for (int ch = NCH; ch < 8; ch++) begin
            cycle(1, 1, ch, 9, 0);
            check_vec("oor_pending", pending_o, '0);
        end
        idle(8);

        // Divisor 1: outputs stuck high.
        cycle(1, 1, 0, 1, 1);
        idle(2);
        check_bit("div1_clk", clk_o[0], 1'b1);
        check_bit("div1_en", en_o[0], 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
                  $urandom_range(0, 39) == 0);
        end

        // Reset mid-period with a pending write, then the default sequence again.
        cycle(1, 1, 3, 6, 0);
        check_bit("pre_rst_pending", pending_o[3], 1'b1);
        cycle(0, 0, 0, 0, 0);
        check_vec("mid_rst_en", en_o, '0);
        check_vec("mid_rst_clk", clk_o, '0);
        check_vec("mid_rst_pending", pending_o, '0);
        check_default_pattern("rst2_seq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
